// File: rtl/ifetch_queue.sv
// Instruction prefetch queue: keeps one fetch outstanding and buffers returned words with their PC+4.
// A redirect flushes the buffer; a fetch still in flight is drained in StDrop and its data dropped.
module ifetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_req,
  output logic [31:0]              imem_addr,
  input  logic                     imem_ack,
  input  logic [31:0]              imem_rdata,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  input  logic                     stall,
  output logic                     inst_valid,
  output logic [31:0]              instruction,
  output logic [31:0]              pc_plus4,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);

  typedef enum logic [1:0] {StIdle, StReq, StDrop} state_e;

  state_e            state_q;
  logic [31:0]       addr_q;
  logic [31:0]       fetch_pc_q;
  logic [CntW-1:0]   count_q;
  logic [PtrW-1:0]   rd_ptr_q;
  logic [PtrW-1:0]   wr_ptr_q;
  logic [31:0]       inst_mem [DEPTH];
  logic [31:0]       pc4_mem  [DEPTH];

  logic              push;
  logic              pop;
  logic [31:0]       next_addr;
  logic [31:0]       target;
  logic [CntW-1:0]   count_after;

  assign inst_valid  = (count_q != '0);
  assign instruction = inst_mem[rd_ptr_q];
  assign pc_plus4    = pc4_mem[rd_ptr_q];
  assign occupancy   = count_q;
  assign imem_req    = (state_q != StIdle);
  assign imem_addr   = addr_q;

  assign pop       = inst_valid & ~stall & ~redirect;
  assign push      = (state_q == StReq) & imem_ack & ~redirect;
  assign next_addr = addr_q + 32'd4;
  assign target    = redirect_pc & ~32'd3;

  always_comb begin
    count_after = count_q + CntW'(push) - CntW'(pop);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      addr_q     <= RESET_PC;
      fetch_pc_q <= RESET_PC;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else if (redirect) begin
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      fetch_pc_q <= target;
      case (state_q)
        StReq, StDrop: begin
          // Without an ack the old request must stay on the bus until memory answers it.
          if (imem_ack) begin
            state_q <= StReq;
            addr_q  <= target;
          end else begin
            state_q <= StDrop;
          end
        end
        default: begin
          state_q <= StReq;
          addr_q  <= target;
        end
      endcase
    end else begin
      count_q <= count_after;
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case (state_q)
        StIdle: begin
          if (count_after < DepthC) begin
            state_q <= StReq;
            addr_q  <= fetch_pc_q;
          end
        end
        StReq: begin
          if (imem_ack) begin
            fetch_pc_q <= next_addr;
            if (count_after < DepthC) addr_q <= next_addr;
            else                      state_q <= StIdle;
          end
        end
        StDrop: begin
          if (imem_ack) begin
            state_q <= StReq;
            addr_q  <= fetch_pc_q;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst && push) begin
      inst_mem[wr_ptr_q] <= imem_rdata;
      pc4_mem[wr_ptr_q]  <= next_addr;
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: directed phases drive a latency-programmable memory model while a
// negedge monitor pops the expected-instruction queue each time the DUT hands over a word.
module tb_ifetch_queue;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        inst_valid;
  logic [31:0] instruction;
  logic [31:0] pc_plus4;
  logic [2:0]  occupancy;

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] inst;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          lat    = 0;
  int          cnt    = 0;
  bit          mem_en = 1'b1;
  logic        force_ack;
  logic        model_ack;
  logic [31:0] model_rdata;

  assign imem_ack   = mem_en ? model_ack : force_ack;
  assign imem_rdata = mem_en ? model_rdata : 32'hBAD0_BAD0;

  ifetch_queue #(
    .DEPTH    (4),
    .RESET_PC (32'h0000_0000)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .stall       (stall),
    .inst_valid  (inst_valid),
    .instruction (instruction),
    .pc_plus4    (pc_plus4),
    .occupancy   (occupancy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_5A00;
  endfunction

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Queue the words the consumer should see, starting at fetch address a0.
  task automatic expect_seq(input logic [31:0] a0, input int n);
    logic [31:0] a;
    exp_t e;
    a = a0;
    for (int i = 0; i < n; i++) begin
      e.pc4  = a + 32'd4;
      e.inst = mem_word(a);
      exp_q.push_back(e);
      a = a + 32'd4;
    end
  endtask

  // Memory model: answers after lat wait cycles, one request at a time.
  initial begin
    model_ack   = 1'b0;
    model_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (imem_req === 1'b1) begin
        if (cnt >= lat) begin
          model_ack   = 1'b1;
          model_rdata = mem_word(imem_addr);
          cnt         = 0;
        end else begin
          model_ack = 1'b0;
          cnt++;
        end
      end else begin
        model_ack = 1'b0;
        cnt       = 0;
      end
    end
  end

  // Scoreboard monitor: a pop happens at the coming edge, so compare the head now.
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b1 && inst_valid === 1'b1 && stall === 1'b0 && redirect === 1'b0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow: got pc_plus4 %h with no entry expected", pc_plus4);
      end else begin
        e = exp_q.pop_front();
        check("sb_pc_plus4", pc_plus4, e.pc4);
        check("sb_instruction", instruction, e.inst);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int max_occ;
    rst         = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    force_ack   = 1'b0;

    // Reset and zero-wait streaming
    tick(); tick(); tick();
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_occ", 32'(occupancy), 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    expect_seq(32'h0, 64);
    rst = 1'b1;
    check("first_cycle_idle", 32'(imem_req), 32'd0);
    tick();
    check("req_rise", 32'(imem_req), 32'd1);
    check("req_addr0", imem_addr, 32'h0);
    check("no_valid_yet", 32'(inst_valid), 32'd0);
    tick();
    check("first_valid", 32'(inst_valid), 32'd1);
    check("first_pc4", pc_plus4, 32'h4);
    check("first_inst", instruction, mem_word(32'h0));
    check("first_occ", 32'(occupancy), 32'd1);
    max_occ = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
    end
    check("stream_max_occ", 32'(max_occ), 32'd1);

    // Stall fills the buffer, fetch stops, release drains in order
    stall = 1'b1;
    for (int i = 0; i < 20 && occupancy != 3'd4; i++) tick();
    check("stall_full_occ", 32'(occupancy), 32'd4);
    check("stall_full_req", 32'(imem_req), 32'd0);
    tick(); tick(); tick();
    check("stall_hold_occ", 32'(occupancy), 32'd4);
    check("stall_hold_req", 32'(imem_req), 32'd0);
    stall = 1'b0;
    for (int i = 0; i < 12; i++) tick();

    // Three wait states, redirect while the fetch at 0x8 is in flight
    rst = 1'b0;
    lat = 3;
    exp_q.delete();
    tick(); tick();
    rst = 1'b1;
    expect_seq(32'h0, 2);
    for (int i = 0; i < 40 && !(imem_req === 1'b1 && imem_addr == 32'h8); i++) tick();
    check("lat_reach_8", imem_addr, 32'h8);
    tick();
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    exp_q.delete();
    expect_seq(32'h100, 32);
    tick();
    redirect = 1'b0;
    check("drop_req", 32'(imem_req), 32'd1);
    check("drop_hold_addr", imem_addr, 32'h8);
    check("drop_occ", 32'(occupancy), 32'd0);
    for (int i = 0; i < 10 && imem_addr == 32'h8; i++) tick();
    check("drop_new_addr", imem_addr, 32'h100);
    check("drop_discard", 32'(occupancy), 32'd0);
    for (int i = 0; i < 20 && inst_valid !== 1'b1; i++) tick();
    check("drop_first_pc4", pc_plus4, 32'h104);
    for (int i = 0; i < 20; i++) tick();

    // Redirect coinciding with ack and pop
    lat = 0;
    tick(); tick(); tick(); tick();
    check("coinc_pre_valid", 32'(inst_valid), 32'd1);
    redirect    = 1'b1;
    redirect_pc = 32'h203;
    exp_q.delete();
    expect_seq(32'h200, 32);
    tick();
    redirect = 1'b0;
    check("coinc_occ", 32'(occupancy), 32'd0);
    check("coinc_valid", 32'(inst_valid), 32'd0);
    check("coinc_addr", imem_addr, 32'h200);
    check("coinc_req", 32'(imem_req), 32'd1);
    for (int i = 0; i < 6; i++) tick();

    // Address wrap at the top of memory
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    exp_q.delete();
    expect_seq(32'hFFFF_FFFC, 32);
    tick();
    redirect = 1'b0;
    check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    tick();
    check("wrap_pc4_0", pc_plus4, 32'h0000_0000);
    tick();
    check("wrap_pc4_1", pc_plus4, 32'h0000_0004);
    for (int i = 0; i < 4; i++) tick();

    // Reset while draining a dropped request, ack lands in the first cycle after reset
    mem_en      = 1'b0;
    force_ack   = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h300;
    exp_q.delete();
    tick();
    redirect = 1'b0;
    check("f_drop_req", 32'(imem_req), 32'd1);
    check("f_drop_occ", 32'(occupancy), 32'd0);
    rst = 1'b0;
    tick();
    check("f_rst_req", 32'(imem_req), 32'd0);
    check("f_rst_occ", 32'(occupancy), 32'd0);
    check("f_rst_valid", 32'(inst_valid), 32'd0);
    check("f_rst_addr", imem_addr, 32'h0);
    rst       = 1'b1;
    force_ack = 1'b1;
    tick();
    force_ack = 1'b0;
    check("f_restart_req", 32'(imem_req), 32'd1);
    check("f_restart_addr", imem_addr, 32'h0);
    check("f_no_push_occ", 32'(occupancy), 32'd0);
    check("f_no_push_valid", 32'(inst_valid), 32'd0);
    lat    = 0;
    mem_en = 1'b1;
    expect_seq(32'h0, 16);
    tick();
    check("f_first_pc4", pc_plus4, 32'h4);
    for (int i = 0; i < 6; i++) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the number of prefetch buffer entries (power of two, 2..16).
REQ-002 Parameter RESET_PC, default 32'h0000_0000, SHALL set the first fetch address after reset.
REQ-003 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  reset, synchronous and active-low (0 = reset, sampled on rising clk).
REQ-005 imem_req  out  1  SHALL indicate that a fetch request to instruction memory is pending.
REQ-006 imem_addr  out  32  SHALL carry the word-aligned fetch address, valid while imem_req=1.
REQ-007 imem_ack  in  1  SHALL indicate that imem_rdata is valid for the pending request; the block ignores it while imem_req=0.
REQ-008 imem_rdata  in  32  instruction word returned by memory.
REQ-009 redirect  in  1  SHALL be the branch-taken/jump pulse from ID.
REQ-010 redirect_pc  in  32  SHALL carry the new fetch target, sampled when redirect=1.
REQ-011 stall  in  1  SHALL indicate a pipeline freeze; the consumer takes no instruction while it is 1.
REQ-012 inst_valid  out  1  SHALL indicate that the buffer head holds a valid instruction.
REQ-013 instruction  out  32  SHALL carry the head instruction word, feeding IF/ID instructionIn.
REQ-014 pc_plus4  out  32  SHALL carry the head instruction address + 4, feeding IF/ID PCplus4In.
REQ-015 occupancy  out  $clog2(DEPTH)+1  SHALL report the current buffer entry count.

Function
REQ-016 The FSM SHALL have three states: IDLE (imem_req=0), REQ (request live), and DROP (request live, result to be discarded).
REQ-017 At most one memory request SHALL be outstanding; while imem_req=1, imem_addr SHALL be held stable until the cycle imem_ack=1.
REQ-018 The block SHALL go IDLE->REQ when count_next < DEPTH, with imem_addr = fetch_pc.
REQ-019 In REQ with imem_ack=1 and no redirect, the block SHALL push {imem_rdata, imem_addr+4} and set fetch_pc = imem_addr+4.
- It SHALL stay in REQ at the new address if the post-update count < DEPTH; otherwise it SHALL go to IDLE.
- Zero-wait memory (ack every cycle) SHALL sustain one instruction per cycle.
REQ-020 Pop SHALL occur when inst_valid=1, stall=0 and redirect=0; instruction/pc_plus4 SHALL then advance to the next entry on the following cycle.
REQ-021 Simultaneous push and pop SHALL leave the count unchanged; a push SHALL never occur when full, guaranteed by REQ-018/019.
REQ-022 Redirect SHALL take priority over push and pop in every state:
- the buffer SHALL be flushed (count=0, inst_valid=0 next cycle);
- fetch_pc SHALL load {redirect_pc[31:2],2'b00}.
REQ-023 Redirect in IDLE SHALL go to REQ next cycle at the new target.
REQ-024 Redirect in REQ with imem_ack=1 SHALL discard the data and go to REQ at the new target.
REQ-025 Redirect in REQ with imem_ack=0 SHALL go to DROP, holding the old imem_addr.
REQ-026 In DROP, imem_ack=1 SHALL discard the data and go to REQ at fetch_pc.
- A further redirect in DROP SHALL overwrite fetch_pc and flush again without leaving DROP unless ack=1.
REQ-027 Address arithmetic SHALL be modulo 2^32 (32'hFFFF_FFFC + 4 = 32'h0000_0000).
REQ-028 stall SHALL block only pops; fetching SHALL continue until the buffer is full.

Reset
REQ-029 While rst=0 the block SHALL apply these values: state=IDLE, count=0, inst_valid=0, imem_req=0, imem_addr=RESET_PC, fetch_pc=RESET_PC, occupancy=0, read/write pointers=0.
REQ-030 Reset during REQ or DROP SHALL abandon the outstanding request; any imem_ack in the first cycle after reset SHALL be ignored.
REQ-031 On the first cycle after rst returns to 1, the block SHALL be in IDLE; imem_req SHALL rise on the next edge with imem_addr=RESET_PC.

Verification
REQ-032 Zero-wait memory, stall=0 -> imem_req=1 from cycle 2; inst_valid=1 from cycle 3 with pc_plus4 = 4, 8, 12, ..., one per cycle, occupancy ≤1.
REQ-033 stall=1 held, DEPTH=4 -> occupancy reaches 4, imem_req=0; release stall -> 4 pops then resumed fetch, no lost or duplicated word.
REQ-034 3-cycle ack latency, redirect to 0x100 one cycle after request at 0x8 -> state DROP, word at 0x8 discarded, next imem_addr=0x100, first output pc_plus4=0x104.
REQ-035 Redirect to 0x203 coinciding with ack and pop -> data discarded, occupancy=0 next cycle, imem_addr=0x200.
REQ-036 redirect_pc=0xFFFF_FFFC, zero-wait -> pc_plus4 sequence 0x0000_0000, 0x0000_0004.
REQ-037 rst=0 asserted while in DROP with ack arriving the next cycle -> all REQ-029 values, no push, imem_addr=RESET_PC after restart.
